pipe_barrel_shifter: RTL and testbench
======================================

Name: pipe_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter for the NPC datapath. Replaces the fixed 8-bit combinational shifter.
- Width is generic. Adds rotate modes, a valid/ready handshake with backpressure, and one register per shift level so it can feed the EXU shift path at full clock rate.
- Throughput is one operation per cycle. Latency is SHW cycles.

Parameters:
- WIDTH, 32: data width. Power of two, at least 8.
- SHW, $clog2(WIDTH): shift-amount width and number of pipeline stages. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input operation valid.
- in_ready  out  1  pipeline can accept this cycle.
- din  in  WIDTH  operand.
- shamt  in  SHW  shift amount, 0..WIDTH-1.
- op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through.
- flush  in  1  synchronous kill of all in-flight operations.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- dout  out  WIDTH  result.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, dout, op and shamt registers go to 0. out_valid=0. in_ready=1 once rst_n is high.
- Structure: stages k=0..SHW-1. Stage k takes its input from the previous stage's register (stage 0 takes din/op/shamt) and shifts by 2^k when shamt[k]=1. Its result plus op, remaining shamt and valid are registered into stage k.
- The final stage register drives dout and out_valid.
- Stage k, SLL: out = {cur[WIDTH-1-2^k:0], 2^k zeros}.
- Stage k, SRL: out = {2^k zeros, cur[WIDTH-1:2^k]}.
- Stage k, SRA: as SRL, but the fill bits are copies of the original din[WIDTH-1], carried down the pipe.
- Stage k, ROL: out = {cur[WIDTH-1-2^k:0], cur[WIDTH-1:WIDTH-2^k]}.
- Stage k, ROR: out = {cur[2^k-1:0], cur[WIDTH-1:2^k]}.
- Pass-through ops: data is unchanged at every stage.
- Advance rule: adv = !out_valid || out_ready. in_ready = adv.
- When adv=1, every stage register loads from its predecessor, and stage 0 loads in_valid/din.
- When adv=0, every stage holds. dout and out_valid stay stable until taken.
- A transfer is accepted when in_valid && in_ready. Its result appears with out_valid=1 exactly SHW cycles later if no stall occurs. Each stall cycle adds one cycle.
- There is no bubble collapsing; the whole pipe stalls together. Consequence: a full pipe sustains 1 op/cycle while out_ready=1.
- flush=1: all valid bits clear on the next edge; data registers don't care. An input presented in the same cycle as flush is dropped. flush overrides adv.
- shamt=0: the result equals din for every op.
- Rotate amounts wrap modulo WIDTH by construction; no range check exists.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: one result leaves and one operation enters in the same cycle.
- Reset mid-operation: all in-flight operations are lost. No output is produced for them.

Optional Feature:
- Macro: BARREL_SHF_CARRY_EN.
- When defined: adds output port cout (1 bit), pipelined alongside dout.
  - cout is 0 at stage 0 entry.
  - At stage k with shamt[k]=1, cout is updated to the last bit shifted or rotated out: cur[WIDTH-2^k] for SLL/ROL, cur[2^k-1] for SRL/SRA/ROR.
  - At stage k with shamt[k]=0, cout holds.
  - Net result: cout is the last bit out of the whole shift, and 0 when shamt=0 or for pass-through ops.
  - cout resets to 0.
- When undefined: no cout port and no carry logic.

Test Plan:
- WIDTH=32, out_ready=1. SLL din=0x0000_0001 shamt=31 -> dout=0x8000_0000, 5 cycles after accept. SRA din=0x8000_0000 shamt=4 -> dout=0xF800_0000.
- ROR din=0x1234_5678 shamt=8 -> dout=0x7812_3456. ROL same din, shamt=4 -> dout=0x2345_6781. Opcode 110 -> dout=din.
- Back-to-back: 5 SRL ops (din=0xFFFF_FFFF, shamt=0..4) issued on consecutive cycles -> dout 0xFFFF_FFFF, 0x7FFF_FFFF, 0x3FFF_FFFF, 0x1FFF_FFFF, 0x0FFF_FFFF on consecutive cycles, in order.
- Backpressure: hold out_ready=0 for 3 cycles with the pipe full -> in_ready=0, dout stable. Release -> all results are delivered with none lost or duplicated.
- flush asserted with 3 ops in flight plus 1 new input -> no out_valid afterwards. The next op accepted after flush completes normally. Assert rst_n low mid-stream -> out_valid=0 immediately (asynchronous).
- With BARREL_SHF_CARRY_EN: SLL din=0x4000_0000 shamt=2 -> dout=0, cout=1. SRL din=0x0000_0002 shamt=1 -> cout=0. shamt=0 -> cout=0.

Source files
------------

// File: rtl/pipe_barrel_shifter_if.sv
// Handshake and data bundle for pipe_barrel_shifter.
// The cout signal exists only when BARREL_SHF_CARRY_EN is defined.
interface pipe_barrel_shifter_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din;
   logic [SHW-1:0]   shamt;
   logic [2:0]       op;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;
`ifdef BARREL_SHF_CARRY_EN
   logic             cout;
`endif

   modport master (
      output in_valid, din, shamt, op, flush, out_ready,
      input  in_ready, out_valid, dout
`ifdef BARREL_SHF_CARRY_EN
      , input cout
`endif
   );

   modport slave (
      input  in_valid, din, shamt, op, flush, out_ready,
      output in_ready, out_valid, dout
`ifdef BARREL_SHF_CARRY_EN
      , output cout
`endif
   );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: one register per shift level, the whole pipe stalls together.
// Optional carry-out (last bit shifted/rotated out) is built when BARREL_SHF_CARRY_EN is defined.
module pipe_barrel_shifter #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipe_barrel_shifter_if.slave  s_bus
);
   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   logic [WIDTH-1:0] r_data  [SHW];
   logic [2:0]       r_op    [SHW];
   logic [SHW-1:0]   r_shamt [SHW];
   logic             r_sign  [SHW];
   logic             r_valid [SHW];

   logic [WIDTH-1:0] w_cur_data  [SHW];
   logic [WIDTH-1:0] w_nxt_data  [SHW];
   logic [2:0]       w_cur_op    [SHW];
   logic [SHW-1:0]   w_cur_shamt [SHW];
   logic             w_cur_sign  [SHW];
   logic             w_cur_valid [SHW];
`ifdef BARREL_SHF_CARRY_EN
   logic             r_cout      [SHW];
   logic             w_cur_cout  [SHW];
   logic             w_nxt_cout  [SHW];
`endif
   logic             w_adv;

   assign w_adv           = !r_valid[SHW-1] || s_bus.out_ready;
   assign s_bus.in_ready  = w_adv;
   assign s_bus.out_valid = r_valid[SHW-1];
   assign s_bus.dout      = r_data[SHW-1];
`ifdef BARREL_SHF_CARRY_EN
   assign s_bus.cout      = r_cout[SHW-1];
`endif

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int S = 1 << k;
      logic [WIDTH-1:0] w_res;

      if (k == 0) begin : g_src
         assign w_cur_data[k]  = s_bus.din;
         assign w_cur_op[k]    = s_bus.op;
         assign w_cur_shamt[k] = s_bus.shamt;
         // SRA fill comes from the operand's original sign, not the partially shifted value
         assign w_cur_sign[k]  = s_bus.din[WIDTH-1];
         assign w_cur_valid[k] = s_bus.in_valid;
`ifdef BARREL_SHF_CARRY_EN
         assign w_cur_cout[k]  = 1'b0;
`endif
      end else begin : g_src
         assign w_cur_data[k]  = r_data[k-1];
         assign w_cur_op[k]    = r_op[k-1];
         assign w_cur_shamt[k] = r_shamt[k-1];
         assign w_cur_sign[k]  = r_sign[k-1];
         assign w_cur_valid[k] = r_valid[k-1];
`ifdef BARREL_SHF_CARRY_EN
         assign w_cur_cout[k]  = r_cout[k-1];
`endif
      end

      always_comb begin
         w_res = w_cur_data[k];
         if (w_cur_shamt[k][k]) begin
            case (w_cur_op[k])
               OP_SLL:  w_res = {w_cur_data[k][WIDTH-1-S:0], {S{1'b0}}};
               OP_SRL:  w_res = {{S{1'b0}}, w_cur_data[k][WIDTH-1:S]};
               OP_SRA:  w_res = {{S{w_cur_sign[k]}}, w_cur_data[k][WIDTH-1:S]};
               OP_ROL:  w_res = {w_cur_data[k][WIDTH-1-S:0], w_cur_data[k][WIDTH-1:WIDTH-S]};
               OP_ROR:  w_res = {w_cur_data[k][S-1:0], w_cur_data[k][WIDTH-1:S]};
               default: w_res = w_cur_data[k];
            endcase
         end
      end
      assign w_nxt_data[k] = w_res;

`ifdef BARREL_SHF_CARRY_EN
      logic w_co;
      always_comb begin
         w_co = w_cur_cout[k];
         if (w_cur_shamt[k][k]) begin
            case (w_cur_op[k])
               OP_SLL, OP_ROL:         w_co = w_cur_data[k][WIDTH-S];
               OP_SRL, OP_SRA, OP_ROR: w_co = w_cur_data[k][S-1];
               default:                w_co = w_cur_cout[k];
            endcase
         end
      end
      assign w_nxt_cout[k] = w_co;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SHW; k++) begin
            r_valid[k] <= 1'b0;
            r_data[k]  <= '0;
            r_op[k]    <= '0;
            r_shamt[k] <= '0;
            r_sign[k]  <= 1'b0;
`ifdef BARREL_SHF_CARRY_EN
            r_cout[k]  <= 1'b0;
`endif
         end
      end else begin
         if (s_bus.flush) begin
            for (int k = 0; k < SHW; k++) r_valid[k] <= 1'b0;
         end else if (w_adv) begin
            for (int k = 0; k < SHW; k++) r_valid[k] <= w_cur_valid[k];
         end
         if (w_adv) begin
            for (int k = 0; k < SHW; k++) begin
               r_data[k]  <= w_nxt_data[k];
               r_op[k]    <= w_cur_op[k];
               r_shamt[k] <= w_cur_shamt[k];
               r_sign[k]  <= w_cur_sign[k];
`ifdef BARREL_SHF_CARRY_EN
               r_cout[k]  <= w_nxt_cout[k];
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed bench for pipe_barrel_shifter (WIDTH=32): latency, ops, back-to-back, stall, flush, reset.
module tb_pipe_barrel_shifter;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pipe_barrel_shifter_if #(.WIDTH(32)) bus ();
   pipe_barrel_shifter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .s_bus(bus));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] din, input logic [4:0] sh);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.din      = din;
      bus.shamt    = sh;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] din,
                         input logic [4:0] sh, input logic [31:0] exp, input logic exp_c);
      int cnt;
      check({tag, " in_ready"}, {31'b0, bus.in_ready}, 32'd1);
      drive(op, din, sh);
      tick();
      cnt = 1;
      bus.in_valid = 1'b0;
      while (!bus.out_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      check({tag, " latency"}, 32'(cnt), 32'd5);
      check({tag, " dout"}, bus.dout, exp);
`ifdef BARREL_SHF_CARRY_EN
      check({tag, " cout"}, {31'b0, bus.cout}, {31'b0, exp_c});
`else
      if (exp_c === 1'bx) $display("unexpected carry value");
`endif
      tick();
      check({tag, " drained"}, {31'b0, bus.out_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.din       = '0;
      bus.shamt     = '0;
      bus.op        = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("reset dout", bus.dout, 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("post-reset in_ready", {31'b0, bus.in_ready}, 32'd1);
`ifdef BARREL_SHF_CARRY_EN
      check("reset cout", {31'b0, bus.cout}, 32'd0);
`endif

      run_op("sll31",   3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
      run_op("sra4",    3'b010, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
      run_op("ror8",    3'b100, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0);
      run_op("rol4",    3'b011, 32'h1234_5678, 5'd4,  32'h2345_6781, 1'b1);
      run_op("pass110", 3'b110, 32'h1234_5678, 5'd5,  32'h1234_5678, 1'b0);
      run_op("sra0",    3'b010, 32'h8000_0001, 5'd0,  32'h8000_0001, 1'b0);
      run_op("srl28",   3'b001, 32'hF000_0000, 5'd28, 32'h0000_000F, 1'b0);
      run_op("srl4c",   3'b001, 32'h0000_0018, 5'd4,  32'h0000_0001, 1'b1);
      run_op("ror1",    3'b100, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1);
      run_op("sll2c",   3'b000, 32'h4000_0000, 5'd2,  32'h0000_0000, 1'b1);
      run_op("srl1c",   3'b001, 32'h0000_0002, 5'd1,  32'h0000_0001, 1'b0);

      // back-to-back SRL of all-ones, shamt 0..4
      for (int i = 0; i < 5; i++) begin
         drive(3'b001, 32'hFFFF_FFFF, 5'(i));
         tick();
      end
      bus.in_valid = 1'b0;
      check("b2b valid0", {31'b0, bus.out_valid}, 32'd1);
      check("b2b dout0", bus.dout, 32'hFFFF_FFFF);
      for (int i = 1; i < 5; i++) begin
         tick();
         check("b2b valid", {31'b0, bus.out_valid}, 32'd1);
         check("b2b dout", bus.dout, 32'hFFFF_FFFF >> i);
      end
      tick();
      check("b2b drained", {31'b0, bus.out_valid}, 32'd0);

      // backpressure with a full pipe: results 0x20,0x22,...,0x2A
      for (int i = 0; i < 5; i++) begin
         drive(3'b000, 32'h10 + 32'(i), 5'd1);
         tick();
      end
      check("bp first dout", bus.dout, 32'h20);
      bus.out_ready = 1'b0;
      drive(3'b000, 32'h15, 5'd1);
      #1;
      check("bp in_ready low", {31'b0, bus.in_ready}, 32'd0);
      for (int j = 0; j < 3; j++) begin
         tick();
         check("bp stall in_ready", {31'b0, bus.in_ready}, 32'd0);
         check("bp stall valid", {31'b0, bus.out_valid}, 32'd1);
         check("bp stall dout", bus.dout, 32'h20);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp release in_ready", {31'b0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("bp res1", bus.dout, 32'h22);
      for (int m = 2; m < 6; m++) begin
         tick();
         check("bp valid", {31'b0, bus.out_valid}, 32'd1);
         check("bp res", bus.dout, 32'h20 + 32'(2 * m));
      end
      tick();
      check("bp drained", {31'b0, bus.out_valid}, 32'd0);

      // flush with three in flight plus one new input
      for (int i = 0; i < 3; i++) begin
         drive(3'b000, 32'h1, 5'd0);
         tick();
      end
      drive(3'b000, 32'h2, 5'd0);
      bus.flush = 1'b1;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("flush no output", {31'b0, bus.out_valid}, 32'd0);
         tick();
      end
      run_op("post-flush", 3'b011, 32'h8000_0001, 5'd1, 32'h0000_0003, 1'b1);

      // asynchronous reset while operations are in flight
      for (int i = 0; i < 4; i++) begin
         drive(3'b001, 32'hFFFF_FFFF, 5'd0);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      check("pre-rst valid", {31'b0, bus.out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst valid", {31'b0, bus.out_valid}, 32'd0);
      check("async rst dout", bus.dout, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("lost after rst", {31'b0, bus.out_valid}, 32'd0);
      end
      run_op("post-rst", 3'b001, 32'h0000_0100, 5'd8, 32'h0000_0001, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
